bemf_sampler: RTL and testbench
===============================

# bemf_sampler

Back-EMF sampling sequencer that sits directly upstream of the quad motor PWM stage and drives its `bemf_sensing` input. On a fixed interval it asserts `bemf_sensing` to gate the shared motor PWM off, waits a settle time for the windings to coast, and runs a req/ack conversion handshake with the ADC front end for motors 0–3 in order. It then publishes all four readings atomically and releases the PWM.

## Interface
Parameters:
- `INTERVAL`, 65536: cycles between window-start opportunities; ≥ 16.
- `SETTLE`, 2048: cycles `bemf_sensing` is high before the first `adc_req`; ≥ 1.
- `TIMEOUT`, 1024: max cycles waiting for `adc_ack` per channel; ≥ 2.
- `DATA_W`, 10: ADC result width.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `sample_en` in 1: permits new windows to start.
- `adc_ack` in 1: ADC conversion done; `adc_data` valid while high.
- `adc_data` in DATA_W: conversion result.
- `bemf_sensing` out 1: high for the whole window; goes to the PWM stage.
- `adc_req` out 1: conversion request, level.
- `adc_chan` out 2: motor index for the current request.
- `bemf0`..`bemf3` out DATA_W each: last published readings.
- `bemf_update` out 1: one-cycle pulse when `bemf0..3` change.
- `bemf_err` out 4: per-channel timeout flag from the last window.

## Operation
- Interval counter:
  - Free-running from 0 to INTERVAL-1, then wraps to 0.
  - A window-start opportunity is the cycle where the count equals INTERVAL-1.
  - A window starts only if the FSM is in IDLE and `sample_en` is high. Otherwise the opportunity is skipped silently.
- FSM states:
  - IDLE: `bemf_sensing` 0, `adc_req` 0. Goes to SETTLE on a window start and loads the settle counter to 0.
  - SETTLE: `bemf_sensing` 1. After SETTLE cycles in this state, goes to REQ with `adc_chan` = 0.
  - REQ: `adc_req` 1, holding `adc_chan`.
    - If `adc_ack` is high, capture `adc_data` into shadow[chan], clear err[chan], and go to RELEASE.
    - If the wait counter reaches TIMEOUT-1 with `adc_ack` still low, write all-ones into shadow[chan], set err[chan], and go to RELEASE.
  - RELEASE: `adc_req` 0.
    - Waits for `adc_ack` low.
    - If `adc_ack` is already low, exits after one cycle: to REQ with chan+1 if chan < 3, else to DONE.
  - DONE: for one cycle, copies shadow0..3 into `bemf0..3` and err into `bemf_err`, pulses `bemf_update`, then goes to IDLE.
- `adc_ack` is ignored outside REQ and RELEASE.
- `adc_chan` holds its last value while in IDLE.
- Deasserting `sample_en` mid-window does not abort the window; it only blocks later windows.
- Outputs `bemf0..3` and `bemf_err` never show a partial window.

## Timing
- Reset values (asynchronous, all outputs): `bemf_sensing` 0, `adc_req` 0, `adc_chan` 0, `bemf0..3` 0, `bemf_update` 0, `bemf_err` 0. Internal state: FSM IDLE, interval counter 0, shadow 0.
- Reset mid-window drops `bemf_sensing` and `adc_req` immediately. Nothing is published.
- All outputs are registered.
- Window start at opportunity cycle T:
  - `bemf_sensing` rises at T+1.
  - `adc_req` first rises at T+1+SETTLE.
- Per channel, with ack arriving k cycles after req rises and dropping immediately: k+2 cycles.
  - `adc_req` falls the cycle after ack is sampled.
  - Next req rises one cycle after ack is seen low.
- Timeout: `adc_req` stays high exactly TIMEOUT cycles, then falls.
- DONE cycle:
  - `bemf_update` = 1 and the new `bemf0..3` / `bemf_err` appear in the same cycle.
  - `bemf_sensing` is still 1 in that cycle and falls the next cycle.
- Minimum window length with immediate acks: 1 + SETTLE + 4×3 + 1 cycles.
- Window longer than INTERVAL: the opportunities that fall inside the window are skipped. The next window starts at the first opportunity seen in IDLE.

## Test plan
- **Normal window.** INTERVAL=64, SETTLE=8, `sample_en`=1, ADC model acks 3 cycles after req with data 0x101, 0x202, 0x303, 0x0FF.
  - `bemf_sensing` rises at cycle 64.
  - First `adc_req` at 72.
  - `adc_chan` goes 0,1,2,3.
  - One `bemf_update` pulse; `bemf0..3` = 0x101/0x202/0x303/0x0FF; `bemf_err`=0.
- **Timeout on channel 2.** TIMEOUT=16, ADC model never acks channel 2.
  - `adc_req` for chan 2 is high exactly 16 cycles.
  - `bemf2` = 0x3FF, `bemf_err` = 4'b0100; other channels are correct.
- **Slow ack release.** Ack held high 5 cycles after capture.
  - No new `adc_req` until ack is low.
  - Data is captured once, from the first ack cycle.
- **Enable gating and skip.**
  - `sample_en`=0: no `bemf_sensing` over 4 intervals.
  - `sample_en` dropped mid-window: the window completes and no further windows start.
  - Window longer than INTERVAL: the overlapped opportunity is skipped.
- **Reset mid-operation.** Assert `rst` during REQ for chan 1.
  - `bemf_sensing` and `adc_req` go to 0 without a clock edge.
  - `bemf0..3` are 0.
  - After release, the first window starts at count INTERVAL-1.
- **Back-to-back windows.** Run 3 consecutive windows.
  - Exactly one `bemf_update` per window.
  - `bemf_sensing` is low for at least 1 cycle between windows.

Source files
------------

// File: rtl/bemf_sampler.sv
// Back-EMF sampling sequencer.
// Every INTERVAL cycles (when enabled and idle) it raises bemf_sensing to gate
// the motor PWM off, waits SETTLE cycles, then converts motors 0..3 in order
// through a req/ack handshake. All four readings and the per-channel timeout
// flags are published in one cycle, marked by a bemf_update pulse.
//
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   sample_en      - permits new windows to start
//   adc_ack        - ADC conversion done, adc_data valid while high
//   adc_data       - ADC result
//   bemf_sensing   - high for the whole window (to the PWM stage)
//   adc_req        - conversion request (level)
//   adc_chan       - motor index of the current request
//   bemf0..bemf3   - last published readings
//   bemf_update    - one-cycle pulse when bemf0..3 / bemf_err change
//   bemf_err       - per-channel timeout flags from the last window
module bemf_sampler #(
    parameter int unsigned INTERVAL = 65536,
    parameter int unsigned SETTLE   = 2048,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned DATA_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              adc_ack,
    input  logic [DATA_W-1:0] adc_data,
    output logic              bemf_sensing,
    output logic              adc_req,
    output logic [1:0]        adc_chan,
    output logic [DATA_W-1:0] bemf0,
    output logic [DATA_W-1:0] bemf1,
    output logic [DATA_W-1:0] bemf2,
    output logic [DATA_W-1:0] bemf3,
    output logic              bemf_update,
    output logic [3:0]        bemf_err
);

    localparam int unsigned INT_W = $clog2(INTERVAL);
    localparam int unsigned SET_W = $clog2(SETTLE) + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_REQ     = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [INT_W-1:0]  ivl_cnt_q, ivl_cnt_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]        chan_q, chan_d;
    logic [DATA_W-1:0] shadow_q [4];
    logic [DATA_W-1:0] shadow_d [4];
    logic [3:0]        err_q, err_d;

    logic              sensing_q, sensing_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] bemf_q [4];
    logic [DATA_W-1:0] bemf_d [4];
    logic              update_q, update_d;
    logic [3:0]        bemf_err_q, bemf_err_d;

    logic win_opp;
    logic settle_done;
    logic timeout_hit;

    assign win_opp     = (ivl_cnt_q == INT_W'(INTERVAL - 1));
    assign settle_done = (settle_cnt_q == SET_W'(SETTLE - 1));
    assign timeout_hit = (wait_cnt_q == TO_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (win_opp && sample_en) state_d = S_SETTLE;
            S_SETTLE:  if (settle_done) state_d = S_REQ;
            S_REQ:     if (adc_ack || timeout_hit) state_d = S_RELEASE;
            S_RELEASE: if (!adc_ack) state_d = (chan_q == 2'd3) ? S_DONE : S_REQ;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Counters, channel index and shadow capture
    always_comb begin
        ivl_cnt_d    = win_opp ? '0 : ivl_cnt_q + INT_W'(1);
        settle_cnt_d = (state_q == S_SETTLE) ? settle_cnt_q + SET_W'(1) : '0;
        wait_cnt_d   = (state_q == S_REQ) ? wait_cnt_q + TO_W'(1) : '0;
        chan_d       = chan_q;
        shadow_d     = shadow_q;
        err_d        = err_q;
        if (state_q == S_SETTLE && state_d == S_REQ) begin
            chan_d = 2'd0;
        end
        if (state_q == S_RELEASE && state_d == S_REQ) begin
            chan_d = chan_q + 2'd1;
        end
        // Ack wins over a coincident timeout
        if (state_q == S_REQ) begin
            if (adc_ack) begin
                shadow_d[chan_q] = adc_data;
                err_d[chan_q]    = 1'b0;
            end else if (timeout_hit) begin
                shadow_d[chan_q] = '1;
                err_d[chan_q]    = 1'b1;
            end
        end
    end

    // Output logic: decoded from the next state so registered outputs align with it
    always_comb begin
        sensing_d  = (state_d != S_IDLE);
        req_d      = (state_d == S_REQ);
        update_d   = (state_d == S_DONE);
        bemf_d     = bemf_q;
        bemf_err_d = bemf_err_q;
        if (state_d == S_DONE) begin
            bemf_d     = shadow_q;
            bemf_err_d = err_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ivl_cnt_q    <= '0;
            settle_cnt_q <= '0;
            wait_cnt_q   <= '0;
            chan_q       <= '0;
            err_q        <= '0;
            sensing_q    <= 1'b0;
            req_q        <= 1'b0;
            update_q     <= 1'b0;
            bemf_err_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                bemf_q[i]   <= '0;
            end
        end else begin
            ivl_cnt_q    <= ivl_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            chan_q       <= chan_d;
            err_q        <= err_d;
            sensing_q    <= sensing_d;
            req_q        <= req_d;
            update_q     <= update_d;
            bemf_err_q   <= bemf_err_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
                bemf_q[i]   <= bemf_d[i];
            end
        end
    end

    assign bemf_sensing = sensing_q;
    assign adc_req      = req_q;
    assign adc_chan     = chan_q;
    assign bemf0        = bemf_q[0];
    assign bemf1        = bemf_q[1];
    assign bemf2        = bemf_q[2];
    assign bemf3        = bemf_q[3];
    assign bemf_update  = update_q;
    assign bemf_err     = bemf_err_q;

endmodule

// File: tb/tb_bemf_sampler.sv
// Testbench for bemf_sampler: ADC responder model, output monitor with a
// scoreboard of expected published windows, and a directed stimulus sequence.
module tb_bemf_sampler;

    localparam int unsigned INTERVAL = 64;
    localparam int unsigned SETTLE   = 8;
    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned DATA_W   = 10;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              sample_en = 1'b0;
    logic              adc_ack   = 1'b0;
    logic [DATA_W-1:0] adc_data  = '0;
    logic              bemf_sensing;
    logic              adc_req;
    logic [1:0]        adc_chan;
    logic [DATA_W-1:0] bemf0, bemf1, bemf2, bemf3;
    logic              bemf_update;
    logic [3:0]        bemf_err;

    bemf_sampler #(
        .INTERVAL(INTERVAL),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT),
        .DATA_W  (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .adc_ack     (adc_ack),
        .adc_data    (adc_data),
        .bemf_sensing(bemf_sensing),
        .adc_req     (adc_req),
        .adc_chan    (adc_chan),
        .bemf0       (bemf0),
        .bemf1       (bemf1),
        .bemf2       (bemf2),
        .bemf3       (bemf3),
        .bemf_update (bemf_update),
        .bemf_err    (bemf_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected published windows
    typedef struct packed {
        logic [DATA_W-1:0] b0;
        logic [DATA_W-1:0] b1;
        logic [DATA_W-1:0] b2;
        logic [DATA_W-1:0] b3;
        logic [3:0]        err;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] data_tab [4];
    logic [3:0]        never_mask = 4'b0000;
    int                ack_dly    = 4;
    int                hold_len   = 1;

    function automatic exp_t model_window();
        exp_t e;
        e.b0  = never_mask[0] ? 10'h3FF : data_tab[0];
        e.b1  = never_mask[1] ? 10'h3FF : data_tab[1];
        e.b2  = never_mask[2] ? 10'h3FF : data_tab[2];
        e.b3  = never_mask[3] ? 10'h3FF : data_tab[3];
        e.err = never_mask;
        return e;
    endfunction

    // ADC responder: ack ack_dly-1 cycles after req rises, hold for hold_len cycles
    int age       = 0;
    int hold_left = 0;
    bit holding   = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            adc_ack = 1'b0;
            holding = 1'b0;
            age     = 0;
        end else if (holding) begin
            if (hold_left == 0) begin
                adc_ack  = 1'b0;
                adc_data = 10'h000;
                holding  = 1'b0;
            end else begin
                hold_left--;
                adc_data = 10'h155;
            end
        end else if (adc_req && !never_mask[adc_chan]) begin
            age++;
            if (age == ack_dly) begin
                adc_ack   = 1'b1;
                adc_data  = data_tab[adc_chan];
                holding   = 1'b1;
                hold_left = hold_len - 1;
                age       = 0;
            end
        end else begin
            age = 0;
        end
    end

    // Cycle index since reset release
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Output monitor
    int         win_cnt = 0;
    int         upd_cnt = 0;
    int         viol    = 0;
    int         min_gap = 1000000;
    int         low_run = 0;
    bit         have_fall = 1'b0;
    int         rise_cyc[$];
    int         req_rise[$];
    int         upd_cyc[$];
    logic [1:0] chan_seq[$];
    int         req_len [4];
    int         cur_len = 0;
    logic       sens_p = 1'b0, req_p = 1'b0, upd_p = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sens_p    = 1'b0;
            req_p     = 1'b0;
            upd_p     = 1'b0;
            have_fall = 1'b0;
        end else begin
            if (bemf_sensing && !sens_p) begin
                win_cnt++;
                rise_cyc.push_back(cyc);
                if (have_fall && low_run < min_gap) min_gap = low_run;
            end
            if (!bemf_sensing && sens_p) begin
                have_fall = 1'b1;
                low_run   = 0;
            end
            if (!bemf_sensing) low_run++;
            if (adc_req && !req_p) begin
                req_rise.push_back(cyc);
                chan_seq.push_back(adc_chan);
                cur_len = 0;
                if (adc_ack) viol++;
            end
            if (adc_req) cur_len++;
            if (!adc_req && req_p) req_len[adc_chan] = cur_len;
            if (upd_p) chk("sensing_falls_after_done", 32'(bemf_sensing), 32'd0);
            if (bemf_update) begin
                upd_cnt++;
                upd_cyc.push_back(cyc);
                chk("done_sensing_high", 32'(bemf_sensing), 32'd1);
                chk("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("bemf0", 32'(bemf0), 32'(e.b0));
                    chk("bemf1", 32'(bemf1), 32'(e.b1));
                    chk("bemf2", 32'(bemf2), 32'(e.b2));
                    chk("bemf3", 32'(bemf3), 32'(e.b3));
                    chk("bemf_err", 32'(bemf_err), 32'(e.err));
                end
            end
            sens_p = bemf_sensing;
            req_p  = adc_req;
            upd_p  = bemf_update;
        end
    end

    task automatic wait_win(input int target, input int budget);
        int n = 0;
        while (win_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("window_count", 32'(win_cnt), 32'(target));
    endtask

    task automatic wait_upd(input int target, input int budget);
        int n = 0;
        while (upd_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("update_count", 32'(upd_cnt), 32'(target));
    endtask

    task automatic wait_req_chan1(input int budget);
        int n = 0;
        while (!(adc_req && adc_chan == 2'd1) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("req_chan1_seen", 32'(adc_req && adc_chan == 2'd1), 32'd1);
    endtask

    int upd_before;

    initial begin
        data_tab  = '{10'h101, 10'h202, 10'h303, 10'h0FF};
        rst       = 1'b1;
        sample_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sensing", 32'(bemf_sensing), 32'd0);
        chk("rst_req", 32'(adc_req), 32'd0);
        chk("rst_chan", 32'(adc_chan), 32'd0);
        chk("rst_bemf0", 32'(bemf0), 32'd0);
        chk("rst_bemf3", 32'(bemf3), 32'd0);
        chk("rst_update", 32'(bemf_update), 32'd0);
        chk("rst_err", 32'(bemf_err), 32'd0);
        rst = 1'b0;

        // Normal window; sample_en dropped mid-window
        sb.push_back(model_window());
        wait_win(1, 200);
        sample_en = 1'b0;
        wait_upd(1, 200);
        chk("a_sensing_rise", 32'(rise_cyc[0]), 32'd64);
        chk("a_first_req", 32'(req_rise[0]), 32'd72);
        for (int i = 0; i < 4; i++) chk("a_chan_seq", 32'(chan_seq[i]), 32'(i));
        chk("a_chan_spacing", 32'(req_rise[1] - req_rise[0]), 32'd5);
        chk("a_update_cycle", 32'(upd_cyc[0]), 32'd92);

        // Enable low: no window over 4 intervals
        repeat (4 * INTERVAL) @(negedge clk);
        #1;
        chk("gate_no_window", 32'(win_cnt), 32'd1);
        chk("gate_no_update", 32'(upd_cnt), 32'd1);

        // Timeout on channel 2
        never_mask = 4'b0100;
        sb.push_back(model_window());
        sample_en = 1'b1;
        wait_win(2, 200);
        sample_en = 1'b0;
        wait_upd(2, 300);
        chk("b_rise_aligned", 32'(rise_cyc[1] % INTERVAL), 32'd0);
        chk("b_req_len_chan2", 32'(req_len[2]), 32'(TIMEOUT));
        chk("b_req_len_chan0", 32'(req_len[0]), 32'd4);

        // Slow ack release
        never_mask = 4'b0000;
        hold_len   = 6;
        data_tab   = '{10'h0AA, 10'h1C3, 10'h2E7, 10'h3F0};
        sb.push_back(model_window());
        sample_en = 1'b1;
        wait_win(3, 200);
        sample_en = 1'b0;
        wait_upd(3, 300);
        chk("c_req_while_ack", 32'(viol), 32'd0);
        chk("c_chan_spacing", 32'(req_rise[9] - req_rise[8]), 32'd10);

        // Window longer than INTERVAL: overlapped opportunity skipped
        hold_len   = 1;
        never_mask = 4'b1111;
        sb.push_back(model_window());
        sb.push_back(model_window());
        sample_en = 1'b1;
        wait_win(5, 400);
        sample_en = 1'b0;
        wait_upd(5, 300);
        chk("d_skip_spacing", 32'(rise_cyc[4] - rise_cyc[3]), 32'(2 * INTERVAL));

        // Back-to-back windows
        never_mask = 4'b0000;
        for (int i = 0; i < 3; i++) sb.push_back(model_window());
        min_gap   = 1000000;
        sample_en = 1'b1;
        wait_win(8, 400);
        sample_en = 1'b0;
        wait_upd(8, 200);
        chk("e_one_update_per_window", 32'(upd_cnt), 32'(win_cnt));
        chk("e_spacing_1", 32'(rise_cyc[6] - rise_cyc[5]), 32'(INTERVAL));
        chk("e_spacing_2", 32'(rise_cyc[7] - rise_cyc[6]), 32'(INTERVAL));
        chk("e_low_gap", 32'(min_gap >= 1), 32'd1);

        // Reset during channel 1 request
        sample_en = 1'b1;
        wait_win(9, 200);
        wait_req_chan1(100);
        upd_before = upd_cnt;
        #1;
        rst = 1'b1;
        #1;
        chk("f_sensing_async", 32'(bemf_sensing), 32'd0);
        chk("f_req_async", 32'(adc_req), 32'd0);
        chk("f_bemf0", 32'(bemf0), 32'd0);
        chk("f_bemf1", 32'(bemf1), 32'd0);
        chk("f_bemf2", 32'(bemf2), 32'd0);
        chk("f_bemf3", 32'(bemf3), 32'd0);
        chk("f_err", 32'(bemf_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.push_back(model_window());
        wait_win(10, 200);
        sample_en = 1'b0;
        chk("f_rise_after_reset", 32'(rise_cyc[9]), 32'd64);
        wait_upd(upd_before + 1, 200);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
